byte_fifo: RTL and testbench
============================

Name: byte_fifo

Overview:
- Single-clock synchronous FIFO that buffers byte-wide data between a producer (write strobe `yazma_cs`) and a consumer (read strobe `okuma_cs`).
- Provides a data-available flag (`ready`) and a sticky overflow flag for writes dropped while full.
- Used as a generic rate-decoupling buffer inside the datapath.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of storage entries; must be a power of two ≥ 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- okuma_cs  input  1  read request, sampled on the clk rising edge.
- yazma_cs  input  1  write request, sampled on the clk rising edge.
- data_in  input  WIDTH  write data, captured when a write is accepted.
- data_out  output  WIDTH  registered read data.
- ready  output  1  high when the FIFO holds at least one entry (not empty).
- overflow  output  1  sticky; set when a write is attempted while full.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - write pointer, read pointer and count = 0.
  - data_out = 0, ready = 0, overflow = 0.
  - Memory contents are don't-care.
  - Reset asserted mid-operation discards all stored data.
- Internal state: memory DEPTH×WIDTH; wr_ptr and rd_ptr, AW bits each, wrapping modulo DEPTH; count of AW+1 bits, range 0..DEPTH.
- Derived flags: full = (count == DEPTH); empty = (count == 0).
- Write accepted = yazma_cs & (~full | okuma_cs).
  - On acceptance: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1.
- Read accepted = okuma_cs & ~empty.
  - On acceptance: data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1.
  - Latency: word appears on data_out the clock edge after the read is accepted (registered output).
  - data_out holds its last value when no read is accepted.
- count update: +1 on write-only, -1 on read-only, unchanged when both or neither are accepted.
- Simultaneous read and write:
  - When full: both accepted; the freed slot is reused; no overflow; count stays DEPTH.
  - When empty: write accepted; read ignored (no fall-through bypass); data_out unchanged; count becomes 1.
- Write while full with no read: data dropped, pointers unchanged, overflow <= 1.
- overflow stays 1 until reset.
- Read while empty: ignored; pointers, count and data_out unchanged; not an error.
- ready = ~empty, registered via count (updates on the same edge as count).
- Pointer wrap from DEPTH-1 to 0 is seamless; ordering is strictly first-in first-out.

Decomposition:
- No shared package needed; WIDTH and DEPTH are module parameters.
- Optional sub-module: fifo_mem (simple dual-port register array, synchronous write, combinational read).
- Pointer and flag logic stays in byte_fifo.

Test Plan:
- Reset: hold rst=0 for 1 cycle with strobes low -> data_out=0, ready=0, overflow=0.
  - Release rst, write 0xC0 -> ready=1 after that edge.
- Write-then-read: write C0..C7 on 8 consecutive edges, with okuma_cs=1 during writes of C5..C7 -> data_out shows C0, C1, C2 on successive edges; no overflow.
- Fill and overflow:
  - Continue writing C8, C9, CA with okuma_cs=0 -> full after CA.
  - Writes CB..CF are dropped; overflow=1 after the CB edge and stays 1.
- Full with simultaneous read and write:
  - Write D0 with okuma_cs=1 -> data_out=C3, still full.
  - Write D1 with read -> data_out=C4.
  - Write D2 with no read -> dropped.
  - Write D3, D4, each with a read -> data_out=C5, then C6.
- Drain:
  - yazma_cs=0, okuma_cs=1 -> data_out sequence C7, C8, C9, CA, D0, D1, D3, D4.
  - ready falls after D4; further reads leave data_out=D4.
  - overflow remains 1.
- Async reset mid-stream: assert rst between clock edges with the FIFO half full -> outputs clear immediately, and the next read returns nothing (ready=0).

Source files
------------

// File: rtl/byte_fifo_pkg.sv
// Shared types for byte_fifo: classification of each cycle's accepted operations.
package byte_fifo_pkg;

    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpWrite = 2'b01,
        OpRead  = 2'b10,
        OpBoth  = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e decode_op(input logic wr_acc, input logic rd_acc);
        return fifo_op_e'({rd_acc, wr_acc});
    endfunction

endpackage

// File: rtl/byte_fifo_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
module byte_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage has no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with registered read data, not-empty flag and sticky overflow.
module byte_fifo
    import byte_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             okuma_cs,
    input  logic             yazma_cs,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ready,
    output logic             overflow
);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    fifo_op_e         op;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

    // A read in the same cycle frees a slot, so a full FIFO still takes the write.
    assign wr_acc = yazma_cs & (~full | okuma_cs);
    assign rd_acc = okuma_cs & ~empty;
    assign op     = decode_op(wr_acc, rd_acc);

    byte_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= rd_data;
            end
            case (op)
                OpWrite: count <= count + 1'b1;
                OpRead:  count <= count - 1'b1;
                default: count <= count;
            endcase
            if (yazma_cs && full && !okuma_cs) begin
                overflow <= 1'b1;
            end
        end
    end

    assign ready = ~empty;

endmodule

// File: tb/tb_byte_fifo.sv
// Bench for byte_fifo: directed vector table, async-reset sequence, randomized model check.
module tb_byte_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;

    logic             clk;
    logic             rst;
    logic             okuma_cs;
    logic             yazma_cs;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             ready;
    logic             overflow;

    int checks;
    int errors;

    byte_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .okuma_cs (okuma_cs),
        .yazma_cs (yazma_cs),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] dout;
        logic       rdy;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic rd, input logic [7:0] din,
                       input logic [7:0] dout, input logic rdy, input logic ovf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.dout = dout; v.rdy = rdy; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic wr, input logic rd, input logic [7:0] din);
        @(negedge clk);
        yazma_cs = wr;
        okuma_cs = rd;
        data_in  = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] dout, input logic rdy,
                              input logic ovf);
        check({tag, ".data_out"}, 32'(data_out), 32'(dout));
        check({tag, ".ready"}, 32'(ready), 32'(rdy));
        check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    endtask

    // Reference model: queue of stored words plus the expected registered outputs.
    logic [7:0] model_q[$];
    logic [7:0] model_dout;
    logic       model_ovf;

    task automatic model_step(input logic wr, input logic rd, input logic [7:0] din);
        bit was_full;
        was_full = (model_q.size() == DEPTH);
        if (rd && model_q.size() > 0) model_dout = model_q.pop_front();
        if (wr && (!was_full || rd)) model_q.push_back(din);
        if (wr && was_full && !rd) model_ovf = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        okuma_cs = 1'b0;
        yazma_cs = 1'b0;
        data_in  = '0;

        // Directed table: {wr, rd, din, expected data_out, ready, overflow}.
        add(1, 0, 8'hC0, 8'h00, 1, 0);
        add(1, 0, 8'hC1, 8'h00, 1, 0);
        add(1, 0, 8'hC2, 8'h00, 1, 0);
        add(1, 0, 8'hC3, 8'h00, 1, 0);
        add(1, 0, 8'hC4, 8'h00, 1, 0);
        add(1, 1, 8'hC5, 8'hC0, 1, 0);
        add(1, 1, 8'hC6, 8'hC1, 1, 0);
        add(1, 1, 8'hC7, 8'hC2, 1, 0);
        add(1, 0, 8'hC8, 8'hC2, 1, 0);
        add(1, 0, 8'hC9, 8'hC2, 1, 0);
        add(1, 0, 8'hCA, 8'hC2, 1, 0);
        add(1, 0, 8'hCB, 8'hC2, 1, 1);
        add(1, 0, 8'hCC, 8'hC2, 1, 1);
        add(1, 0, 8'hCD, 8'hC2, 1, 1);
        add(1, 0, 8'hCE, 8'hC2, 1, 1);
        add(1, 0, 8'hCF, 8'hC2, 1, 1);
        add(1, 1, 8'hD0, 8'hC3, 1, 1);
        add(1, 1, 8'hD1, 8'hC4, 1, 1);
        add(1, 0, 8'hD2, 8'hC4, 1, 1);
        add(1, 1, 8'hD3, 8'hC5, 1, 1);
        add(1, 1, 8'hD4, 8'hC6, 1, 1);
        add(0, 1, 8'h00, 8'hC7, 1, 1);
        add(0, 1, 8'h00, 8'hC8, 1, 1);
        add(0, 1, 8'h00, 8'hC9, 1, 1);
        add(0, 1, 8'h00, 8'hCA, 1, 1);
        add(0, 1, 8'h00, 8'hD0, 1, 1);
        add(0, 1, 8'h00, 8'hD1, 1, 1);
        add(0, 1, 8'h00, 8'hD3, 1, 1);
        add(0, 1, 8'h00, 8'hD4, 0, 1);
        add(0, 1, 8'h00, 8'hD4, 0, 1);
        add(0, 1, 8'h00, 8'hD4, 0, 1);
        add(1, 1, 8'hE0, 8'hD4, 1, 1);  // empty: write taken, read ignored
        add(0, 1, 8'h00, 8'hE0, 0, 1);

        // Reset held for a cycle with strobes low.
        @(posedge clk);
        #1;
        check_outs("reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].din);
            check_outs($sformatf("vec%0d", i), vecs[i].dout, vecs[i].rdy, vecs[i].ovf);
        end

        // Async reset mid-stream with a few words stored and data_out non-zero.
        step(1, 0, 8'h11);
        step(1, 0, 8'h22);
        step(1, 0, 8'h33);
        step(0, 1, 8'h00);
        check_outs("pre_arst", 8'h11, 1'b1, 1'b1);
        @(negedge clk);
        yazma_cs = 1'b0;
        okuma_cs = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_outs("arst_now", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, 8'h00);
        check_outs("post_arst_rd", 8'h00, 1'b0, 1'b0);

        // Randomized traffic against the queue model; write bias shifts per phase.
        model_q.delete();
        model_dout = 8'h00;
        model_ovf  = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic       wr;
            logic       rd;
            logic [7:0] din;
            int         wr_pct;
            wr_pct = (n < 200) ? 75 : ((n < 400) ? 30 : 55);
            wr  = ($urandom_range(99) < wr_pct);
            rd  = ($urandom_range(99) < 100 - wr_pct);
            din = 8'($urandom);
            step(wr, rd, din);
            model_step(wr, rd, din);
            check_outs($sformatf("rnd%0d", n), model_dout, model_q.size() != 0, model_ovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
